// File: rtl/pe_flow_ctrl.sv
// pe_flow_ctrl: job-level flow control between an input FIFO, a PE that
// processes 4x4 tiles, and an output FIFO. Tiles are issued only while
// output credit is available, then results are counted back until the job
// completes.
module pe_flow_ctrl #(
  parameter int unsigned OUT_DEPTH_BITS = 3,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,        // asynchronous, active-low
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] ctx_length,
  input  logic                 in_empty,
  output logic                 in_re,
  output logic                 pe_next,
  input  logic                 pe_next_out,
  output logic                 out_we,
  input  logic                 out_re,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Credit counter has one extra bit so it can hold the full FIFO depth.
  localparam int unsigned          CRED_W   = OUT_DEPTH_BITS + 1;
  localparam logic [CRED_W-1:0]    CRED_MAX = CRED_W'(1) << OUT_DEPTH_BITS;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] issued_q, issued_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic [CRED_W-1:0]    cred_q, cred_d;
  logic                 out_we_q;
  logic                 err_q, err_d;

  logic                 start_ok;
  logic                 issue;
  logic                 drain_rd;
  logic                 we_counts;
  logic [CNT_WIDTH:0]   accounted;
  logic                 none_in_flight;
  logic                 err_event;

  // Decode issue / retire / error events from the current state.
  always_comb begin
    start_ok       = start && (state_q == IDLE);
    issue          = (state_q == RUN) && !in_empty && (issued_q < len_q) &&
                     (cred_q < CRED_MAX);
    // A consumer read with no credit outstanding is a protocol error and
    // must not underflow the counter.
    drain_rd       = out_re && (cred_q != '0);
    // A result strobe landing in IDLE belongs to no job and is not counted.
    we_counts      = out_we_q && (state_q != IDLE);
    // Results already retired plus the one in the delay register; if that
    // already covers every issued tile, a new PE result cannot be genuine.
    accounted      = {1'b0, retired_q} + {{CNT_WIDTH{1'b0}}, we_counts};
    none_in_flight = accounted >= {1'b0, issued_q};
    err_event      = (out_re && (cred_q == '0)) ||
                     (pe_next_out && none_in_flight) ||
                     (out_we_q && (state_q == IDLE));
  end

  // Next-state logic for the FSM and all counters, plus output decode.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    len_d     = len_q;
    issued_d  = issued_q;
    retired_d = retired_q;
    cred_d    = cred_q;
    err_d     = err_q | err_event;
    in_re     = issue;
    pe_next   = issue;
    out_we    = out_we_q;
    busy      = (state_q == RUN) || (state_q == DRAIN);
    done      = (state_q == DONE);
    err       = err_q;

    if (issue) begin
      issued_d = issued_q + CNT_ONE;
    end
    if (we_counts && (retired_q != CNT_MAX)) begin
      retired_d = retired_q + CNT_ONE;
    end
    unique case ({issue, drain_rd})
      2'b10:   cred_d = cred_q + CRED_W'(1);
      2'b01:   cred_d = cred_q - CRED_W'(1);
      default: cred_d = cred_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = ctx_length;
          issued_d  = '0;
          retired_d = '0;
          cred_d    = '0;
          err_d     = 1'b0;
          state_d   = (ctx_length != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (issue && ((issued_q + CNT_ONE) == len_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (retired_q == len_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start_ok) begin
      err_d = 1'b0;
    end
  end

  // State register; reset aborts any job and clears every counter.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      cred_q    <= '0;
      out_we_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      cred_q    <= cred_d;
      out_we_q  <= pe_next_out;
      err_q     <= err_d;
    end
  end

endmodule
